data_mem_access: RTL
====================

# data_mem_access

Load/store access unit between the single-cycle CPU's memory stage and the data port (port b) of the shared instruction/data memory. It converts RISC-V byte, halfword and word loads/stores into word-wide accesses on a synchronous-read memory with one-cycle read latency. Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended. The CPU is stalled through a valid/ready handshake.

## Interface
- ADDR_W, 14, memory word-address width (16384 words)
- DATA_W, 32, data width; only 32 is supported
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU access request
- req_ready  out  1  unit idle and accepting; a request transfers when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for sb/sh)
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal access; qualified by rsp_valid
- mem_addr  out  ADDR_W  word address to memory port b
- mem_we  out  1  memory write enable
- mem_wdata  out  32  word written when mem_we = 1
- mem_rdata  in  32  memory read data, valid one cycle after mem_addr is presented

## Operation
- FSM states: IDLE, RD, DATA, WR, RESP. req_ready = 1 only in IDLE.
- On acceptance, latch we, funct3, the byte offset req_addr[1:0], the word index req_addr[ADDR_W+1:2] and wdata.
  - Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- Errors are decided in IDLE and go IDLE→RESP with rsp_err = 1 and no memory access:
  - funct3 ∈ {011, 110, 111};
  - a store with funct3[2] = 1;
  - h/hu with addr[0] = 1;
  - w with addr[1:0] ≠ 00.
- sw: IDLE→WR→RESP. The WR word is req_wdata.
- Load: IDLE→RD→DATA→RESP.
  - In DATA, select lane(s) from mem_rdata and register the extended result into rsp_rdata.
- sb/sh: IDLE→RD→DATA→WR→RESP.
  - In DATA, merge into mem_rdata and register the result as the WR word.
  - sb replaces byte lane addr[1:0] with wdata[7:0].
  - sh replaces half addr[1] with wdata[15:0].
- Lanes are little-endian: byte k = bits [8k+7:8k], half j = bits [16j+15:16j].
- Extension: b/h sign-extend from bit 7/15; bu/hu zero-extend; w passes through.
- mem_addr = latched word index in every non-IDLE state and holds its last value in IDLE.
- mem_we = 1 only in WR. mem_wdata holds the last write word.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- rsp_rdata and rsp_err hold until the next RESP overwrites them.
- req_valid while busy is ignored. The requester must hold the request until req_ready.

## Timing
- Reset values (applied on the edge where rst = 1):
  - state IDLE, req_ready 1;
  - rsp_valid 0, rsp_err 0, rsp_rdata 0;
  - mem_addr 0, mem_we 0, mem_wdata 0.
- Cycle counts below are from the acceptance edge (cycle 0 = IDLE with req_valid) to the rsp_valid cycle:
  - error: 1;
  - sw: 2;
  - load: 3;
  - sb/sh: 4.
- Next acceptance is possible the cycle after RESP, giving throughput of 1 access per 3/4/5 cycles.
- mem_rdata is sampled only in DATA, one cycle after RD presented mem_addr.
- rst in any state forces IDLE at that edge.
  - A pending store is dropped. mem_we is 0 from the cycle after that edge.
  - WR is a single cycle, so no partial word is ever written.
  - No rsp_valid is produced for the aborted access.
- rst and req_valid in the same cycle: reset wins and the request is not accepted.

## Test plan
- Reset: hold rst for 2 cycles.
  - Required: req_ready = 1; rsp_valid, mem_we and rsp_rdata all 0; mem_addr = 0.
- sw: addr 0x0000_0004, data 0xDEADBEEF.
  - Next cycle: mem_addr = 1, mem_we = 1, mem_wdata = 0xDEADBEEF.
  - rsp_valid 2 cycles after acceptance with rsp_err = 0.
  - A following lw 0x4 returns 0xDEADBEEF 3 cycles after its acceptance.
- sb: addr 0x6, wdata 0x0000_00A5 over 0xDEADBEEF.
  - WR cycle writes 0xDEA5BEEF.
  - lb 0x6 → 0xFFFFFFA5; lbu 0x6 → 0x000000A5.
- lh/lhu 0x6 on word 0xDEA5BEEF → 0xFFFFDEA5 / 0x0000DEA5.
- sh addr 0x6, wdata 0x1234 → word 0x1234BEEF.
- Errors, each with mem_we never asserted:
  - sh 0x5 → rsp_valid + rsp_err one cycle after acceptance;
  - lw 0x2 → same;
  - funct3 = 011 → same.
- Reset mid-access: sb in flight, rst asserted during the DATA cycle.
  - Required: no mem_we pulse, no rsp_valid.
  - req_ready = 1 the next cycle.
  - Memory word unchanged (0xDEA5BEEF).

Source files
------------

// File: rtl/data_mem_access_if.sv
// data_mem_access_if: CPU-side request/response handshake for the data memory access unit
interface data_mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_access.sv
// data_mem_access: byte/half/word load-store unit over a one-cycle-latency word memory, sub-word stores by read-modify-write
module data_mem_access #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_access_if.slave     bus,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;
    state_t state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic              req_err;
    logic [4:0]        sh;
    logic [DATA_W-1:0] mask, merged, ld_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    always_comb begin
        req_err  = bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11 ||
                   (bus.req_we && bus.req_funct3[2]) ||
                   (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00);
        sh       = f3_q[0] ? {off_q[1], 4'b0000} : {off_q, 3'b000};
        mask     = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merged   = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
        byte_sel = 8'(mem_rdata >> {off_q, 3'b000});
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data  = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_sel[7]}}, byte_sel} :
                   f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_sel[15]}}, half_sel} : mem_rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            we_q          <= 1'b0;
            f3_q          <= '0;
            off_q         <= '0;
            wdata_q       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q          <= bus.req_we;
                    f3_q          <= bus.req_funct3;
                    off_q         <= bus.req_addr[1:0];
                    wdata_q       <= bus.req_wdata;
                    mem_addr      <= bus.req_addr[ADDR_W+1:2];
                    bus.req_ready <= 1'b0;
                    if (req_err) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
                        state     <= WR;
                        mem_we    <= 1'b1;
                        mem_wdata <= bus.req_wdata;
                    end else begin
                        state <= RD;
                    end
                end
                RD: state <= DATA;
                DATA: if (we_q) begin
                    state     <= WR;
                    mem_we    <= 1'b1;
                    mem_wdata <= merged;
                end else begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= ld_data;
                end
                WR: begin
                    state         <= RESP;
                    mem_we        <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= '0;
                end
                default: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
